// File: rtl/pwm_duty_meas.sv
// pwm_duty_meas: measures period, active time and 8-bit duty of a PWM input,
// and flags a stuck line when no active edge arrives within a timeout.
`timescale 1ns/1ps
module pwm_duty_meas #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = CLK_FREQ / 100,
  parameter logic        ACTIVE_LVL  = 1'b1
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic [7:0]       duty_out,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_lvl,
  output logic             overrun
);

  localparam int unsigned REM_W  = CNT_W + 1;
  localparam int unsigned QUO_W  = 9;
  localparam int unsigned STEP_W = 4;
  localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(QUO_W - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state;
  logic               sync_a;
  logic               synced;
  logic               hist;
  logic [CNT_W-1:0]   per_cnt;
  logic [CNT_W-1:0]   hi_cnt;
  logic [CNT_W-1:0]   div_p;
  logic [CNT_W-1:0]   cap_h;
  logic [REM_W-1:0]   rem;
  logic [QUO_W-1:0]   quo;
  logic [STEP_W-1:0]  step;
  logic               busy;

  logic               active_c;
  logic               aedge_c;
  logic               timeout_c;
  logic [REM_W-1:0]   div_ext_c;
  logic               rem_ge_c;
  logic [REM_W-1:0]   rem_sub_c;
  logic [REM_W-1:0]   rem_shift_c;
  logic [QUO_W-1:0]   quo_next_c;
  logic [7:0]         duty_clamp_c;

  // Two-flop synchronizer plus history flop for edge detection
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync_a <= ~ACTIVE_LVL;
      synced <= ~ACTIVE_LVL;
      hist   <= ~ACTIVE_LVL;
    end else begin
      sync_a <= pwm_in;
      synced <= sync_a;
      hist   <= synced;
    end
  end

  assign active_c  = (synced == ACTIVE_LVL);
  assign aedge_c   = active_c && (hist != ACTIVE_LVL);
  assign timeout_c = (state != ST_IDLE) && (per_cnt == TIMEOUT_VAL);

  // One restoring-division step: remainder stays below 2*P, so one extra bit suffices
  assign div_ext_c    = {1'b0, div_p};
  assign rem_ge_c     = (rem >= div_ext_c);
  assign rem_sub_c    = rem_ge_c ? (rem - div_ext_c) : rem;
  assign rem_shift_c  = rem_sub_c << 1;
  assign quo_next_c   = {quo[QUO_W-2:0], rem_ge_c};
  assign duty_clamp_c = quo_next_c[QUO_W-1] ? 8'hFF : quo_next_c[7:0];

  // Counters, capture FSM, serial divider and registered outputs
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      div_p      <= '0;
      cap_h      <= '0;
      rem        <= '0;
      quo        <= '0;
      step       <= '0;
      busy       <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      duty_out   <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
      stuck_lvl  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      overrun    <= 1'b0;

      // Edge-referenced counters; held at zero while idle
      if (aedge_c) begin
        per_cnt <= CNT_ONE;
        hi_cnt  <= CNT_ONE;
      end else if (state == ST_IDLE) begin
        per_cnt <= '0;
        hi_cnt  <= '0;
      end else begin
        if (per_cnt != TIMEOUT_VAL) per_cnt <= per_cnt + CNT_ONE;
        if (active_c)               hi_cnt  <= hi_cnt + CNT_ONE;
      end

      // Divider iteration; last step publishes the measurement
      if (busy) begin
        rem  <= rem_shift_c;
        quo  <= quo_next_c;
        step <= step + STEP_W'(1);
        if (step == LAST_STEP) begin
          busy       <= 1'b0;
          period_out <= div_p;
          high_out   <= cap_h;
          duty_out   <= duty_clamp_c;
          meas_valid <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (aedge_c) begin
            state <= ST_ARMED;
            stuck <= 1'b0;
          end
        end
        ST_ARMED, ST_RUN: begin
          if (timeout_c) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            stuck      <= 1'b1;
            stuck_lvl  <= synced;
            period_out <= '0;
            high_out   <= '0;
            duty_out   <= active_c ? 8'hFF : 8'h00;
            meas_valid <= 1'b1;
          end else if (aedge_c) begin
            if (busy) begin
              overrun <= 1'b1;
            end else begin
              state <= ST_RUN;
              div_p <= per_cnt;
              cap_h <= hi_cnt;
              rem   <= {1'b0, hi_cnt};
              quo   <= '0;
              step  <= '0;
              busy  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Directed bench for pwm_duty_meas with hand-computed expected measurements.
`timescale 1ns/1ps
module tb_pwm_duty_meas;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 5000;

  logic             sys_clk = 1'b0;
  logic             rst_n   = 1'b0;
  logic             pwm_in  = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic [7:0]       duty_out;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_lvl;
  logic             overrun;

  int unsigned cyc       = 0;
  int unsigned last_rise = 0;
  int unsigned ovr_cnt   = 0;
  int unsigned n_chk     = 0;
  int unsigned n_bad     = 0;

  typedef struct {
    int unsigned per;
    int unsigned hi;
    int unsigned duty;
    int unsigned lat;
  } rec_t;
  rec_t recs[$];

  pwm_duty_meas #(
    .CLK_FREQ   (50_000_000),
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT),
    .ACTIVE_LVL (1'b1)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .period_out(period_out),
    .high_out  (high_out),
    .duty_out  (duty_out),
    .meas_valid(meas_valid),
    .stuck     (stuck),
    .stuck_lvl (stuck_lvl),
    .overrun   (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Log every published measurement and overrun pulse, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (meas_valid)
      recs.push_back('{per: period_out, hi: high_out, duty: 32'(duty_out), lat: cyc - last_rise});
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic drive_period(input int p, input int h);
    pwm_in    = 1'b1;
    last_rise = cyc;
    tick(h);
    pwm_in = 1'b0;
    tick(p - h);
  endtask

  task automatic drive_n(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) drive_period(p, h);
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    rst_n  = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    recs.delete();
    ovr_cnt = 0;
  endtask

  task automatic check_rec(input string tag, input int idx, input int p, input int h, input int d);
    rec_t r;
    r = '{per: 0, hi: 0, duty: 0, lat: 0};
    if (idx < recs.size()) r = recs[idx];
    check({tag, ".period"}, r.per, p);
    check({tag, ".high"}, r.hi, h);
    check({tag, ".duty"}, r.duty, d);
  endtask

  int tp[3] = '{100, 257, 256};
  int th[3] = '{99, 256, 1};
  int td[3] = '{253, 255, 1};

  initial begin
    // Reset state
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst.period", period_out, 0);
    check("rst.high", high_out, 0);
    check("rst.duty", 32'(duty_out), 0);
    check("rst.valid", 32'(meas_valid), 0);
    check("rst.stuck", 32'(stuck), 0);
    check("rst.stuck_lvl", 32'(stuck_lvl), 0);
    check("rst.overrun", 32'(overrun), 0);

    // Steady 1000/250: first edge only arms, then one measurement per edge
    recs.delete();
    drive_period(1000, 250);
    check("first_edge.count", recs.size(), 0);
    drive_n(1000, 250, 3);
    tick(5);
    check("p1000.count", recs.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_rec($sformatf("p1000[%0d]", i), i, 1000, 250, 64);
      check($sformatf("p1000[%0d].latency", i), (i < recs.size()) ? recs[i].lat : 0, 12);
    end

    // Duty arithmetic boundary cases
    for (int k = 0; k < 3; k++) begin
      do_reset();
      drive_n(tp[k], th[k], 3);
      tick(20);
      check($sformatf("duty%0d.count", k), recs.size(), 2);
      check_rec($sformatf("duty%0d", k), 1, tp[k], th[k], td[k]);
    end

    // Line stuck high after a few periods
    do_reset();
    drive_n(1000, 250, 3);
    recs.delete();
    pwm_in    = 1'b1;
    last_rise = cyc;
    tick(5100);
    check("stuck_hi.count", recs.size(), 2);
    check_rec("stuck_hi.last", 0, 1000, 250, 64);
    check_rec("stuck_hi.tmo", 1, 0, 0, 255);
    check("stuck_hi.tmo_latency", (recs.size() > 1) ? recs[1].lat : 0, 5003);
    check("stuck_hi.stuck", 32'(stuck), 1);
    check("stuck_hi.lvl", 32'(stuck_lvl), 1);

    // Line stuck low, then PWM restarts
    do_reset();
    drive_n(1000, 250, 3);
    recs.delete();
    tick(4500);
    check("stuck_lo.count", recs.size(), 1);
    check_rec("stuck_lo.tmo", 0, 0, 0, 0);
    check("stuck_lo.tmo_latency", (recs.size() > 0) ? recs[0].lat : 0, 5003);
    check("stuck_lo.stuck", 32'(stuck), 1);
    check("stuck_lo.lvl", 32'(stuck_lvl), 0);
    drive_period(1000, 250);
    check("restart.stuck_cleared", 32'(stuck), 0);
    check("restart.first_edge_count", recs.size(), 1);
    drive_period(1000, 250);
    check("restart.count", recs.size(), 2);
    check_rec("restart.meas", 1, 1000, 250, 64);

    // Short period: every other edge lands in the busy window
    do_reset();
    drive_n(6, 3, 11);
    tick(20);
    check("ovr.pulses", ovr_cnt, 5);
    check("ovr.count", recs.size(), 5);
    for (int i = 0; i < 5; i++)
      check_rec($sformatf("ovr[%0d]", i), i, 6, 3, 128);

    // Reset while the divider is busy
    do_reset();
    drive_n(1000, 250, 3);
    recs.delete();
    pwm_in    = 1'b1;
    last_rise = cyc;
    tick(5);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(20);
    check("midrst.count", recs.size(), 0);
    check("midrst.period", period_out, 0);
    check("midrst.high", high_out, 0);
    check("midrst.duty", 32'(duty_out), 0);
    drive_n(1000, 250, 2);
    tick(5);
    check("midrst.resume_count", recs.size(), 1);
    check_rec("midrst.resume", 0, 1000, 250, 64);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_meas.md
Name: pwm_duty_meas

Overview:
Measures an incoming single-bit PWM waveform, such as an LED/PWM drive line looped back or from an external source. For each full period it reports the period length, the active-level time, and an 8-bit duty value in 1/256 units, which is the inverse of our PWM/breath generators. It also flags a stuck line when no edge arrives within a timeout. It is used for self-check loopback of LED drivers and for reading external PWM controls.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz (documentation/derivation only)
CNT_W, 32, width of period/high counters and outputs; must hold TIMEOUT_CYC
TIMEOUT_CYC, CLK_FREQ/100, cycles without an active edge before stuck is declared (10 ms default)
ACTIVE_LVL, 1'b1, level of pwm_in counted as "on"

Ports:
sys_clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
pwm_in  input  1  asynchronous PWM input
period_out  output  CNT_W  last measured period in sys_clk cycles
high_out  output  CNT_W  last measured active-level cycles within that period
duty_out  output  8  floor(high_out*256/period_out), clamped to 255
meas_valid  output  1  one-cycle pulse: outputs just updated
stuck  output  1  level: timeout occurred, no edge since
stuck_lvl  output  1  synchronized pwm_in level at timeout
overrun  output  1  one-cycle pulse: capture discarded because the divider was busy

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs go to 0.
  - Synchronizer flops are set to ~ACTIVE_LVL.
  - Counters are cleared and the FSM returns to IDLE.
  - Reset mid-measurement or mid-division abandons all work, and no meas_valid is produced.
- Input path:
  - 2-FF synchronizer, then a history flop.
  - Active edge (aedge) is the cycle where the synced value becomes ACTIVE_LVL from ~ACTIVE_LVL.
- Counters, all timing referenced to the aedge cycle:
  - On aedge: per_cnt<=1, hi_cnt<=1.
  - Otherwise: per_cnt<=per_cnt+1, and hi_cnt<=hi_cnt+1 when synced==ACTIVE_LVL.
  - At the next aedge, per_cnt equals the exact edge-to-edge cycle count P, and hi_cnt equals the active cycles H.
- FSM states: IDLE, ARMED, RUN.
  - IDLE: counters held at 0. On aedge go to ARMED with the counters started. No output.
  - ARMED/RUN: on aedge, capture P and H into holding regs and start the divider. The state becomes RUN. Counters restart on the same cycle.
  - Timeout: per_cnt==TIMEOUT_CYC in ARMED/RUN. Then:
    - stuck<=1, stuck_lvl<=synced level.
    - period_out<=0, high_out<=0.
    - duty_out<=255 if synced==ACTIVE_LVL, else 0.
    - meas_valid pulses once and the FSM goes to IDLE.
  - Timeout takes priority over a simultaneous aedge.
  - stuck clears on the next aedge seen in IDLE.
- Divider:
  - Sequential restoring division of {H,8'b0} by P, 9 quotient bits, one bit per cycle.
  - Busy in cycles T+1..T+9, where T is the capture aedge cycle.
  - In cycle T+10: period_out<=P, high_out<=H, duty_out<=min(quotient,255), and meas_valid=1 for exactly that cycle.
  - Total pwm_in-to-meas_valid latency is 12-13 cycles.
- Overrun:
  - An aedge during the busy window (P<10) is not captured, and overrun pulses for 1 cycle.
  - Counters still restart on that aedge.
  - The in-flight division completes normally.
- Arithmetic:
  - Guaranteed H<=P and P>=1, so there is no divide-by-zero.
  - A quotient of 256 (H==P is only possible via the timeout path) is clamped to 255.
  - per_cnt stops at TIMEOUT_CYC and never wraps.

Test Plan:
- Bench uses TIMEOUT_CYC=5000. After reset, all outputs are 0 and the first aedge gives no meas_valid.
- Steady PWM, P=1000, H=250 -> each period meas_valid pulses with period_out=1000, high_out=250, duty_out=64, exactly 10 cycles after the synced aedge.
- P=100, H=99 -> duty_out=253. P=257, H=256 -> duty_out=255. P=256, H=1 -> duty_out=1.
- pwm_in held at 1 after a few periods -> after 5000 cycles: stuck=1, stuck_lvl=1, duty_out=255, period_out=0, and one meas_valid. Same with pwm_in held at 0 -> duty_out=0, stuck_lvl=0. A restarted PWM clears stuck at the first edge, and a valid measurement follows at the second edge.
- P=6, H=3 -> overrun pulses on alternating edges, and every reported measurement shows period_out=6, duty_out=128.
- Assert rst_n=0 for 1 cycle during divider busy -> no meas_valid. All outputs are 0, and measurement resumes from IDLE.
